instruction_write_arbiter: RTL and testbench

- Shares the single write port of the paired instruction FIFOs (dataA/dataB, written on clk_50) among N_REQ independent instruction sources, e.g. HPS bridge and on-chip sprite/DMA sequencer.
- Edge-detects each requester's start level and latches that requester's instruction words.
- Grants requesters round-robin and issues exactly one single-cycle FIFO write per grant, honouring the FIFO full flag.
- Replaces the single-source write pulse generator in front of the FIFOs.

---
 rtl/instruction_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_instruction_write_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_write_arbiter.sv
// Round-robin arbiter sharing the instruction FIFO write port (dataA/dataB)
// among N_REQ sources. Each source raises a start level; the rising edge
// latches its instruction words, and every grant produces exactly one
// single-cycle FIFO write, spaced at least three clocks apart.
module instruction_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_start,
    input  logic [N_REQ*DATA_W-1:0] req_dataA,
    input  logic [N_REQ*DATA_W-1:0] req_dataB,
    input  logic                    overrun_clr,
    input  logic                    wrfull,
    output logic                    fifo_wrreq,
    output logic [DATA_W-1:0]       fifo_dataA,
    output logic [DATA_W-1:0]       fifo_dataB,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        req_pending,
    output logic [N_REQ-1:0]        req_overrun
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   grant_q;
    logic [PTR_W-1:0]   ptr_d;
    logic               fifo_wrreq_q;
    logic [DATA_W-1:0]  fifo_dataA_q;
    logic [DATA_W-1:0]  fifo_dataB_q;
    logic [N_REQ-1:0]   req_done_q;

    logic [N_REQ-1:0]   start_q;
    logic [N_REQ-1:0]   pending_q;
    logic [N_REQ-1:0]   pending_d;
    logic [N_REQ-1:0]   overrun_q;
    logic [N_REQ-1:0]   overrun_d;
    logic [N_REQ-1:0]   rise;
    logic [N_REQ-1:0]   issue_clr;
    logic [N_REQ-1:0]   capture;

    logic [DATA_W-1:0]  hold_a_q [N_REQ];
    logic [DATA_W-1:0]  hold_b_q [N_REQ];

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;

    // Request bookkeeping: edge detect, pending set/clear, sticky overrun.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        rise      = req_start & ~start_q;
        issue_clr = '0;
        if (state_q == ISSUE) begin
            issue_clr[grant_q] = 1'b1;
        end
        // A rise in the same cycle the pending bit is retired re-arms it.
        capture   = rise & ~(pending_q & ~issue_clr);
        pending_d = (pending_q & ~issue_clr) | rise;
        overrun_d = overrun_clr ? '0 : overrun_q;
        overrun_d = overrun_d | (rise & pending_q & ~issue_clr);
    end

    // Round-robin pick: first pending index at or after the pointer.
    always_comb begin : grant_scan
        int sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            if (!grant_found && pending_q[PTR_W'(sum)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(sum);
            end
        end
    end

    // Pointer advances to the requester after the one just served.
    always_comb begin
        ptr_d = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    // Start history, pending and overrun registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            start_q   <= '1;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            start_q   <= req_start;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Instruction holding registers, loaded on an accepted rise.
    always_ff @(posedge clk) begin
        // NOTE: the holding array has no reset; it is only read while its
        // pending bit is set, and that bit is always cleared by reset.
        for (int i = 0; i < N_REQ; i++) begin
            if (capture[i]) begin
                hold_a_q[i] <= req_dataA[i*DATA_W +: DATA_W];
                hold_b_q[i] <= req_dataB[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant FSM with registered FIFO write outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            fifo_wrreq_q <= 1'b0;
            fifo_dataA_q <= '0;
            fifo_dataB_q <= '0;
            req_done_q   <= '0;
        end else begin
            fifo_wrreq_q <= 1'b0;
            req_done_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (!wrfull && grant_found) begin
                        grant_q      <= grant_idx;
                        fifo_dataA_q <= hold_a_q[grant_idx];
                        fifo_dataB_q <= hold_b_q[grant_idx];
                        fifo_wrreq_q <= 1'b1;
                        req_done_q   <= N_REQ'(1) << grant_idx;
                        state_q      <= ISSUE;
                    end
                end
                // The write is already on the bus; full is not re-checked.
                ISSUE: begin
                    ptr_q   <= ptr_d;
                    state_q <= SETTLE;
                end
                // Gives the FIFO a cycle to update its full flag.
                SETTLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_wrreq  = fifo_wrreq_q;
    assign fifo_dataA  = fifo_dataA_q;
    assign fifo_dataB  = fifo_dataB_q;
    assign req_done    = req_done_q;
    assign req_pending = pending_q;
    assign req_overrun = overrun_q;

endmodule

// File: tb/tb_instruction_write_arbiter.sv
// Self-checking bench for instruction_write_arbiter (N_REQ=2). A behavioural
// model tracks requests and a busy countdown; directed scenarios plus a
// random phase are compared against it every cycle.
module tb_instruction_write_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_start;
    logic [N_REQ*DATA_W-1:0] req_dataA;
    logic [N_REQ*DATA_W-1:0] req_dataB;
    logic                    overrun_clr;
    logic                    wrfull;
    logic                    fifo_wrreq;
    logic [DATA_W-1:0]       fifo_dataA;
    logic [DATA_W-1:0]       fifo_dataB;
    logic [N_REQ-1:0]        req_done;
    logic [N_REQ-1:0]        req_pending;
    logic [N_REQ-1:0]        req_overrun;

    instruction_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .req_start   (req_start),
        .req_dataA   (req_dataA),
        .req_dataB   (req_dataB),
        .overrun_clr (overrun_clr),
        .wrfull      (wrfull),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_dataA  (fifo_dataA),
        .fifo_dataB  (fifo_dataB),
        .req_done    (req_done),
        .req_pending (req_pending),
        .req_overrun (req_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_mism = 0;
    int cyc    = 0;

    // Reference model state
    logic [N_REQ-1:0]  m_hist;
    logic [N_REQ-1:0]  m_pend;
    logic [N_REQ-1:0]  m_ovr;
    logic [DATA_W-1:0] m_a [N_REQ];
    logic [DATA_W-1:0] m_b [N_REQ];
    int                m_ptr;
    int                m_grant;
    int                m_lock;
    logic              e_wrreq;
    logic [DATA_W-1:0] e_da;
    logic [DATA_W-1:0] e_db;
    logic [N_REQ-1:0]  e_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock edge of the behavioural model; m_lock counts the edges the
    // arbiter stays busy after a grant (2 = write on the bus, 1 = settling).
    task automatic model_step();
        logic [N_REQ-1:0] pend_old;
        logic [N_REQ-1:0] rise;
        logic [N_REQ-1:0] clr;
        logic [N_REQ-1:0] newovr;
        bit               found;
        if (!rst_n) begin
            m_hist  = '1;
            m_pend  = '0;
            m_ovr   = '0;
            m_ptr   = 0;
            m_grant = 0;
            m_lock  = 0;
            e_wrreq = 1'b0;
            e_da    = '0;
            e_db    = '0;
            e_done  = '0;
        end else begin
            pend_old = m_pend;
            rise     = req_start & ~m_hist;
            clr      = '0;
            e_wrreq  = 1'b0;
            e_done   = '0;
            if (m_lock == 2) begin
                clr[m_grant] = 1'b1;
                m_ptr        = (m_grant + 1) % N_REQ;
                m_lock       = 1;
            end else if (m_lock == 1) begin
                m_lock = 0;
            end else if (!wrfull && pend_old != '0) begin
                found = 1'b0;
                for (int k = 0; k < N_REQ; k++) begin
                    int j;
                    j = (m_ptr + k) % N_REQ;
                    if (!found && pend_old[j]) begin
                        found   = 1'b1;
                        m_grant = j;
                    end
                end
                e_da             = m_a[m_grant];
                e_db             = m_b[m_grant];
                e_wrreq          = 1'b1;
                e_done[m_grant]  = 1'b1;
                m_lock           = 2;
            end
            newovr = rise & pend_old & ~clr;
            for (int i = 0; i < N_REQ; i++) begin
                if (rise[i] && !newovr[i]) begin
                    m_a[i] = req_dataA[i*DATA_W +: DATA_W];
                    m_b[i] = req_dataB[i*DATA_W +: DATA_W];
                end
            end
            m_pend = (pend_old & ~clr) | rise;
            if (overrun_clr) m_ovr = '0;
            m_ovr  = m_ovr | newovr;
            m_hist = req_start;
        end
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("wrreq",   64'(fifo_wrreq),  64'(e_wrreq));
        check("dataA",   64'(fifo_dataA),  64'(e_da));
        check("dataB",   64'(fifo_dataB),  64'(e_db));
        check("done",    64'(req_done),    64'(e_done));
        check("pending", 64'(req_pending), 64'(m_pend));
        check("overrun", 64'(req_overrun), 64'(m_ovr));
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
        req_start[i]                 = v;
        req_dataA[i*DATA_W +: DATA_W] = a;
        req_dataB[i*DATA_W +: DATA_W] = b;
    endtask

    // Bounded wait for the next FIFO write strobe.
    task automatic wait_write(output int at, output logic [N_REQ-1:0] who, output logic [31:0] da);
        bit found;
        found = 1'b0;
        at    = -1;
        who   = '0;
        da    = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (fifo_wrreq) begin
                found = 1'b1;
                at    = cyc;
                who   = req_done;
                da    = fifo_dataA;
            end
        end
        check("wait_write_bound", 64'(found), 64'd1);
    endtask

    task automatic count_writes(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (fifo_wrreq) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                at1;
        int                at2;
        int                cnt;
        int                t;
        logic [N_REQ-1:0]  who1;
        logic [N_REQ-1:0]  who2;
        logic [31:0]       d1;
        logic [31:0]       d2;

        rst_n       = 1'b0;
        req_start   = '0;
        req_dataA   = '0;
        req_dataB   = '0;
        overrun_clr = 1'b0;
        wrfull      = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_wrreq",   64'(fifo_wrreq),  64'd0);
        check("rst_pending", 64'(req_pending), 64'd0);
        check("rst_dataA",   64'(fifo_dataA),  64'd0);
        rst_n = 1'b1;
        repeat (6) tick();

        // Single request: write two edges after the rise is sampled
        set_req(0, 1'b1, 32'h0000_1234, 32'h00AB_CDEF);
        tick();
        check("single_pend_set",  64'(req_pending), 64'h1);
        check("single_no_wr_yet", 64'(fifo_wrreq),  64'd0);
        tick();
        check("single_wrreq", 64'(fifo_wrreq), 64'd1);
        check("single_dataA", 64'(fifo_dataA), 64'h0000_1234);
        check("single_dataB", 64'(fifo_dataB), 64'h00AB_CDEF);
        check("single_done",  64'(req_done),   64'h1);
        tick();
        check("single_wr_off",   64'(fifo_wrreq),  64'd0);
        check("single_pend_clr", 64'(req_pending), 64'd0);
        check("single_hold_A",   64'(fifo_dataA),  64'h0000_1234);
        set_req(0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();

        // Fairness with ptr=1 (after the lone req 0 grant): order 1 then 0
        set_req(0, 1'b1, 32'hA000_0000, 32'hA1);
        set_req(1, 1'b1, 32'hB000_0000, 32'hB1);
        wait_write(at1, who1, d1);
        wait_write(at2, who2, d2);
        check("fair1_first",  64'(who1),      64'b10);
        check("fair1_second", 64'(who2),      64'b01);
        check("fair1_dA1",    64'(d1),        64'hB000_0000);
        check("fair1_dA2",    64'(d2),        64'hA000_0000);
        check("fair1_gap",    64'(at2 - at1), 64'd3);
        set_req(0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();

        // Lone req 1 grant moves ptr to 0; then both rise: order 0 then 1
        set_req(1, 1'b1, 32'hC000_0000, 32'hC1);
        wait_write(at1, who1, d1);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        set_req(0, 1'b1, 32'hD000_0000, 32'hD1);
        set_req(1, 1'b1, 32'hE000_0000, 32'hE1);
        wait_write(at1, who1, d1);
        wait_write(at2, who2, d2);
        check("fair0_first",  64'(who1),      64'b01);
        check("fair0_second", 64'(who2),      64'b10);
        check("fair0_gap",    64'(at2 - at1), 64'd3);
        set_req(0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();

        // Backpressure: no write while full, write one edge after release
        wrfull = 1'b1;
        set_req(1, 1'b1, 32'hF00D_0001, 32'hF1);
        count_writes(20, cnt);
        check("bp_no_write", 64'(cnt), 64'd0);
        check("bp_pending",  64'(req_pending), 64'b10);
        t = cyc;
        wrfull = 1'b0;
        tick();
        check("bp_release_edge", 64'(cyc - t),    64'd1);
        check("bp_wrreq",        64'(fifo_wrreq), 64'd1);
        check("bp_dataA",        64'(fifo_dataA), 64'hF00D_0001);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();

        // Overrun: second rise while pending is dropped and flagged
        wrfull = 1'b1;
        set_req(0, 1'b1, 32'h1111_1111, 32'h11);
        tick();
        set_req(0, 1'b0, 32'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 32'h2222_2222, 32'h22);
        tick();
        check("ovr_set", 64'(req_overrun), 64'h1);
        set_req(0, 1'b0, 32'h0, 32'h0);
        wrfull = 1'b0;
        wait_write(at1, who1, d1);
        check("ovr_who",   64'(who1), 64'h1);
        check("ovr_dataX", 64'(d1),   64'h1111_1111);
        count_writes(10, cnt);
        check("ovr_single_write", 64'(cnt), 64'd0);
        check("ovr_sticky", 64'(req_overrun), 64'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", 64'(req_overrun), 64'h0);
        repeat (2) tick();

        // Reset during ISSUE with the other requester pending; starts held
        // high through release must not count as new requests
        set_req(0, 1'b1, 32'h3333_0000, 32'h33);
        set_req(1, 1'b1, 32'h4444_0000, 32'h44);
        wait_write(at1, who1, d1);
        rst_n = 1'b0;
        tick();
        check("rstmid_wrreq",   64'(fifo_wrreq),  64'd0);
        check("rstmid_done",    64'(req_done),    64'd0);
        check("rstmid_pending", 64'(req_pending), 64'd0);
        check("rstmid_dataA",   64'(fifo_dataA),  64'd0);
        tick();
        rst_n = 1'b1;
        count_writes(12, cnt);
        check("rstmid_no_write", 64'(cnt), 64'd0);

        // Toggle req 0 after reset release: exactly one write
        set_req(0, 1'b0, 32'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 32'h5555_5555, 32'h55);
        count_writes(10, cnt);
        check("toggle_one_write", 64'(cnt), 64'd1);
        set_req(0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        // Random phase against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom;
            rst_n       = ($urandom_range(0, 199) != 0);
            wrfull      = ($urandom_range(0, 3) == 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (r[i*3 +: 2] == 2'b00) req_start[i] = ~req_start[i];
                req_dataA[i*DATA_W +: DATA_W] = $urandom;
                req_dataB[i*DATA_W +: DATA_W] = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
